aim_decode_stage: RTL and testbench

Buffered, pipelined instruction-decode stage for the AIM front end. It accepts 32-bit instruction words over a valid/ready handshake into a DEPTH-entry queue and classifies each word as AI, GFX or illegal. It assembles two-word extended-immediate instructions and presents one registered decoded bundle per instruction to the AI/graphics dispatch logic over a second valid/ready handshake.

---
 rtl/aim_decode_stage.sv | 124 ++++++++++++
 tb/tb_aim_decode_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/aim_decode_stage.sv
// aim_decode_stage: queued AIM instruction decode with two-word extended immediates.
// Define AIM_DECODE_PERF_EN to add the perf_ai_cnt/perf_gfx_cnt handshake counters.
module aim_decode_stage #(
  parameter int          DEPTH      = 4,
  parameter logic [5:0]  EXT_OPCODE = 6'h3F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_is_ai,
  output logic        out_is_gfx,
  output logic        out_illegal,
  output logic [5:0]  out_opcode,
  output logic [3:0]  out_sub_type,
  output logic [7:0]  out_src_reg,
  output logic [7:0]  out_dst_reg,
  output logic [31:0] out_imm,
  output logic        out_has_ext
`ifdef AIM_DECODE_PERF_EN
  ,
  output logic [31:0] perf_ai_cnt,
  output logic [31:0] perf_gfx_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {HEAD, EXT_WAIT} state_e;
  typedef struct packed {
    logic        ai;
    logic        gfx;
    logic        ill;
    logic [5:0]  opc;
    logic [3:0]  sub;
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [31:0] imm;
    logic        ext;
  } bundle_t;
  logic [31:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  state_e      state_q;
  bundle_t     lat_q, out_q, dec, bun_d;
  logic        out_valid_q, full, empty, push, pop, head_ext;
  logic [31:0] head;
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty    = wptr_q == rptr_q;
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = !empty && (!out_valid_q || out_ready) && !flush;
  assign head     = mem_q[rptr_q[AW-1:0]];
  always_comb begin
    dec.ai  = head[31:28] == 4'b0001;
    dec.gfx = head[31:28] == 4'b0010;
    dec.ill = !(dec.ai || dec.gfx);
    dec.opc = head[23:18];
    dec.sub = dec.ill ? 4'h0 : head[27:24];
    dec.src = head[17:10];
    dec.dst = head[9:2];
    dec.imm = {24'h0, head[7:0]};
    dec.ext = 1'b0;
    head_ext = !dec.ill && dec.opc == EXT_OPCODE;
    // In EXT_WAIT the head word is the raw immediate, never a classified instruction.
    bun_d = (state_q == EXT_WAIT) ? lat_q : dec;
    bun_d.imm = (state_q == EXT_WAIT) ? head : dec.imm;
    bun_d.ext = state_q == EXT_WAIT;
  end
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q[AW-1:0]] <= in_instr;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      state_q     <= HEAD;
      lat_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      state_q     <= HEAD;
      out_valid_q <= 1'b0;
    end else begin
      wptr_q <= wptr_q + (AW+1)'(push);
      rptr_q <= rptr_q + (AW+1)'(pop);
      if (out_ready) out_valid_q <= 1'b0;
      if (pop && state_q == HEAD && head_ext) begin
        state_q <= EXT_WAIT;
        lat_q   <= dec;
      end else if (pop) begin
        state_q     <= HEAD;
        out_q       <= bun_d;
        out_valid_q <= 1'b1;
      end
    end
  end
  assign out_valid    = out_valid_q;
  assign out_is_ai    = out_q.ai;
  assign out_is_gfx   = out_q.gfx;
  assign out_illegal  = out_q.ill;
  assign out_opcode   = out_q.opc;
  assign out_sub_type = out_q.sub;
  assign out_src_reg  = out_q.src;
  assign out_dst_reg  = out_q.dst;
  assign out_imm      = out_q.imm;
  assign out_has_ext  = out_q.ext;
`ifdef AIM_DECODE_PERF_EN
  logic [31:0] ai_cnt_q, gfx_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ai_cnt_q  <= '0;
      gfx_cnt_q <= '0;
    end else begin
      if (out_valid_q && out_ready && out_q.ai)  ai_cnt_q  <= ai_cnt_q + 32'd1;
      if (out_valid_q && out_ready && out_q.gfx) gfx_cnt_q <= gfx_cnt_q + 32'd1;
    end
  end
  assign perf_ai_cnt  = ai_cnt_q;
  assign perf_gfx_cnt = gfx_cnt_q;
`endif
endmodule

// File: tb/tb_aim_decode_stage.sv
// tb_aim_decode_stage: directed and random checks of aim_decode_stage against a word-stream model.
module tb_aim_decode_stage;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic        in_ready, out_valid, out_is_ai, out_is_gfx, out_illegal, out_has_ext;
  logic [5:0]  out_opcode;
  logic [3:0]  out_sub_type;
  logic [7:0]  out_src_reg, out_dst_reg;
  logic [31:0] out_imm;
`ifdef AIM_DECODE_PERF_EN
  logic [31:0] perf_ai_cnt, perf_gfx_cnt;
`endif
  int cmp = 0, err = 0;
  logic [31:0] wq[$];
  int m_ai = 0, m_gfx = 0;

  aim_decode_stage #(.DEPTH(DEPTH), .EXT_OPCODE(6'h3F)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_is_ai(out_is_ai), .out_is_gfx(out_is_gfx), .out_illegal(out_illegal),
    .out_opcode(out_opcode), .out_sub_type(out_sub_type), .out_src_reg(out_src_reg),
    .out_dst_reg(out_dst_reg), .out_imm(out_imm), .out_has_ext(out_has_ext)
`ifdef AIM_DECODE_PERF_EN
    , .perf_ai_cnt(perf_ai_cnt), .perf_gfx_cnt(perf_gfx_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cmp++;
    assert (got === exp) else begin
      err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] obs();
    return {2'b0, out_is_ai, out_is_gfx, out_illegal, out_opcode, out_sub_type,
            out_src_reg, out_dst_reg, out_imm, out_has_ext};
  endfunction

  function automatic logic [63:0] bun(logic ai, logic gfx, logic ill, logic [5:0] opc,
                                      logic [3:0] sub, logic [7:0] src, logic [7:0] dst,
                                      logic [31:0] imm, logic ext);
    return {2'b0, ai, gfx, ill, opc, sub, src, dst, imm, ext};
  endfunction

  function automatic bit is_ext(logic [31:0] w);
    return (w[31:28] == 4'd1 || w[31:28] == 4'd2) && w[23:18] == 6'h3F;
  endfunction

  // Expected bundle straight from the instruction-word rules: class, fields, immediate.
  function automatic logic [63:0] model(logic [31:0] w0, logic [31:0] w1);
    bit ai, gfx, ext;
    ai  = w0[31:28] == 4'd1;
    gfx = w0[31:28] == 4'd2;
    ext = is_ext(w0);
    return bun(ai, gfx, !(ai || gfx), w0[23:18], (ai || gfx) ? w0[27:24] : 4'h0,
               w0[17:10], w0[9:2], ext ? w1 : {24'h0, w0[7:0]}, ext);
  endfunction

  always @(negedge clk) begin
    int n;
    if (rst) begin
      wq.delete();
      m_ai  = 0;
      m_gfx = 0;
    end else begin
      if (out_valid && out_ready) begin
        n = (wq.size() > 0 && is_ext(wq[0])) ? 2 : 1;
        chk("words_behind_bundle", 64'(wq.size() >= n), 64'd1);
        if (wq.size() >= n) begin
          chk("bundle", obs(), model(wq[0], n == 2 ? wq[1] : 32'h0));
          if (wq[0][31:28] == 4'd1) m_ai++;
          if (wq[0][31:28] == 4'd2) m_gfx++;
          repeat (n) void'(wq.pop_front());
        end
      end
      if (flush) wq.delete();
      else if (in_valid && in_ready) wq.push_back(in_instr);
    end
  end

  initial begin
    int acc, sent, got;
    logic [31:0] r, w;
    logic [3:0] cls;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_instr = '0;
    tick(); tick();
    chk("in_ready_in_reset", 64'(in_ready), 64'd0);
    rst = 1'b0;
    tick();
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);
    chk("out_valid_after_reset", 64'(out_valid), 64'd0);
    chk("data_after_reset", obs(), 64'd0);
    // single AI word, two-cycle latency
    in_valid = 1'b1; in_instr = 32'h1A0C_0805;
    tick();
    in_valid = 1'b0;
    chk("latency_not_early", 64'(out_valid), 64'd0);
    tick();
    chk("ai_valid", 64'(out_valid), 64'd1);
    chk("ai_bundle", obs(), bun(1, 0, 0, 6'h03, 4'hA, 8'h02, 8'h01, 32'h5, 0));
    // extended GFX pair
    in_valid = 1'b1; in_instr = 32'h23FC_0000;
    tick();
    in_instr = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0;
    chk("ext_no_partial", 64'(out_valid), 64'd0);
    tick();
    chk("ext_valid", 64'(out_valid), 64'd1);
    chk("ext_bundle", obs(), bun(0, 1, 0, 6'h3F, 4'h3, 8'h00, 8'h00, 32'hDEAD_BEEF, 1));
    tick();
    chk("ext_single_bundle", 64'(out_valid), 64'd0);
    // illegal word with EXT opcode, followed by an independent word
    in_valid = 1'b1; in_instr = 32'h5FFF_FFFF;
    tick();
    in_instr = 32'h1A0C_0805;
    tick();
    in_valid = 1'b0;
    chk("illegal_bundle", obs(), bun(0, 0, 1, 6'h3F, 4'h0, 8'hFF, 8'hFF, 32'hFF, 0));
    tick();
    chk("after_illegal", obs(), bun(1, 0, 0, 6'h03, 4'hA, 8'h02, 8'h01, 32'h5, 0));
    tick();
`ifdef AIM_DECODE_PERF_EN
    chk("perf_ai_directed", 64'(perf_ai_cnt), 64'd2);
    chk("perf_gfx_directed", 64'(perf_gfx_cnt), 64'd1);
`endif
    // backpressure: queue plus output register absorb DEPTH+1 words
    out_ready = 1'b0; in_valid = 1'b1; acc = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      in_instr = 32'h1000_0000 | acc;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("absorbed_words", 64'(acc), 64'(DEPTH + 1));
    chk("in_ready_full", 64'(in_ready), 64'd0);
    chk("held_first", 64'(out_imm), 64'd0);
    // drain in order while streaming past pointer wrap
    sent = acc; got = 0;
    for (int c = 0; c < 400 && got < 3 * DEPTH; c++) begin
      in_valid  = sent < 3 * DEPTH;
      in_instr  = 32'h1000_0000 | sent;
      out_ready = ($urandom % 2) == 0;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk("drain_order", 64'(out_imm), 64'(got));
        got++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("drain_count", 64'(got), 64'(3 * DEPTH));
    tick();
    chk("drained_empty", 64'(out_valid), 64'd0);
    // flush while waiting for an extension word
    in_valid = 1'b1; in_instr = 32'h13FC_0000;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'hCAFE_BABE;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    tick();
    chk("flush_dropped_word", 64'(out_valid), 64'd0);
    in_valid = 1'b1; in_instr = 32'h2A0C_0805;
    tick();
    in_valid = 1'b0;
    tick();
    chk("post_flush_head", obs(), bun(0, 1, 0, 6'h03, 4'hA, 8'h02, 8'h01, 32'h5, 0));
    tick();
    // random traffic against the word-stream model
    for (int c = 0; c < 3000; c++) begin
      r   = $urandom;
      cls = (r[1:0] == 2'd0) ? 4'd1 : (r[1:0] == 2'd1) ? 4'd2 : r[5:2];
      w   = $urandom;
      in_instr  = {cls, w[27:24], (r[7:6] == 2'd0) ? 6'h3F : w[23:18], w[17:0]};
      in_valid  = r[9:8] != 2'd0;
      out_ready = r[11:10] != 2'd0;
      flush     = r[17:12] == 6'd0;
      rst       = r[26:18] == 9'd0;
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) tick();
    chk("final_idle", 64'(out_valid), 64'd0);
    chk("final_leftover", 64'(wq.size() <= 1), 64'd1);
`ifdef AIM_DECODE_PERF_EN
    chk("perf_ai_final", 64'(perf_ai_cnt), 64'(m_ai));
    chk("perf_gfx_final", 64'(perf_gfx_cnt), 64'(m_gfx));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
